// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM state encoding, nibble width and a ceil-log2 helper.
// Used by this converter and by the binary->BCD display decoder.
package bcd_pkg;

  localparam int unsigned BCD_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_e;

  // Ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_a_binario_if.sv
// Valid/ready bus for the BCD->binary converter: packed BCD request in, binary result out.
interface bcd_a_binario_if
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BIN_W      = 7
);

  localparam int unsigned IN_W = BCD_NIBBLE_W * NUM_DIGITS;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  // Producer/consumer side of the converter.
  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  // Converter side.
  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd_mul10_suma.sv
// Combinational step of the conversion: acc_out = acc_in*10 + digit, truncated to BIN_W.
module bcd_mul10_suma
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 7
) (
  input  logic [BIN_W-1:0]        acc_in,
  input  logic [BCD_NIBBLE_W-1:0] digit,
  output logic [BIN_W-1:0]        acc_out
);

  logic [BIN_W-1:0] acc_x8;
  logic [BIN_W-1:0] acc_x2;

  // x10 as x8 + x2; overflow bits are intentionally dropped.
  always_comb begin
    acc_x8  = acc_in << 3;
    acc_x2  = acc_in << 1;
    acc_out = acc_x8 + acc_x2 + BIN_W'(digit);
  end

endmodule

// File: rtl/bcd_a_binario.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Optional feature macro: BCD_CHECK_EN (flag nibbles > 9 through err, force bin_out to 0).
module bcd_a_binario
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BIN_W      = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  bcd_a_binario_if.slave bus
);

  localparam int unsigned IN_W  = BCD_NIBBLE_W * NUM_DIGITS;
  localparam int unsigned CNT_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  bcd_state_e       state_q, state_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [BIN_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q,   err_d;
  logic [BIN_W-1:0] acc_nxt_c;
  logic             bad_c;

  bcd_mul10_suma #(.BIN_W(BIN_W)) u_mul10 (
    .acc_in  (acc_q),
    .digit   (shift_q[IN_W-1 -: BCD_NIBBLE_W]),
    .acc_out (acc_nxt_c)
  );

`ifdef BCD_CHECK_EN
  // Flag any non-decimal nibble in the incoming word.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bus.bcd_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] > 4'd9) bad_c = 1'b1;
    end
  end
`else
  assign bad_c = 1'b0;
`endif

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          shift_d = bus.bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = bad_c;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_d   = acc_nxt_c;
        shift_d = shift_q << BCD_NIBBLE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bin_d   = err_q ? '0 : acc_nxt_c;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_q;
`ifdef BCD_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed bench for bcd_a_binario (NUM_DIGITS=2, BIN_W=7).
// Honours BCD_CHECK_EN the same way as the design.
module tb_bcd_a_binario;

  localparam int unsigned ND = 2;
  localparam int unsigned BW = 7;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  bcd_a_binario_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus ();

  bcd_a_binario #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Full transaction: wait for accept, check latency, result and handshake.
  task automatic run(input logic [7:0] bcd, input logic [6:0] exp_bin,
                     input logic exp_err, input string tag);
    int  n;
    bit  ok;
    bus.in_valid = 1'b1;
    bus.bcd_in   = bcd;
    ok = 1'b0;
    for (n = 0; n < 20; n++) begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
    chk({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(ND));
    chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_vld_clr"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bin", 32'(bus.bin_out), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: max value
    run(8'h99, 7'd99, 1'b0, "t1_99");

    // 2: back-to-back 00 then 47, second held while busy
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bcd_in    = 8'h00;
    @(posedge clk); #1;                 // accept 00
    bus.bcd_in = 8'h47;
    chk("t2_rdy_k", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t2_rdy_k1", 32'(bus.in_ready), 32'd0);
    chk("t2_vld_k1", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t2_vld_k2", 32'(bus.out_valid), 32'd1);
    chk("t2_bin0", 32'(bus.bin_out), 32'd0);
    chk("t2_rdy_k2", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;                 // handshake
    chk("t2_vld_k3", 32'(bus.out_valid), 32'd0);
    chk("t2_rdy_k3", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;                 // accept 47
    bus.in_valid = 1'b0;
    chk("t2_rdy_k4", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_vld_47", 32'(bus.out_valid), 32'd1);
    chk("t2_bin47", 32'(bus.bin_out), 32'd47);
    @(posedge clk); #1;
    chk("t2_done", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // 3: stalled consumer
    bus.in_valid = 1'b1;
    bus.bcd_in   = 8'h58;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_hold_vld", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_bin", 32'(bus.bin_out), 32'd58);
      chk("t3_hold_rdy", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_hs_vld", 32'(bus.out_valid), 32'd0);
    chk("t3_hs_rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // 4: reset during conversion
    bus.in_valid = 1'b1;
    bus.bcd_in   = 8'h63;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("t4_rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("t4_rst_bin", 32'(bus.bin_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_vld", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    run(8'h12, 7'd12, 1'b0, "t4_12");

    // 5: invalid nibble
`ifdef BCD_CHECK_EN
    run(8'h1A, 7'd0, 1'b1, "t5_1a");
    run(8'h10, 7'd10, 1'b0, "t5_10");
`else
    run(8'h1A, 7'd20, 1'b0, "t5_1a");
    run(8'hF0, 7'd22, 1'b0, "t5_f0");   // 150 mod 128
`endif

    // 6: all valid two-digit BCD values
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        run({4'(t), 4'(u)}, 7'(t * 10 + u), 1'b0, "t6_sweep");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
